// File: rtl/r_empty.sv
// r_empty: read-side pointer, empty/almost-empty flags and fill level for the async output FIFO.
// Optional sticky underflow flag is compiled in when R_UNDERFLOW_EN is defined.
`default_nettype none
`timescale 1ns/1ps

module r_empty #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic              r_clk,
  input  logic              n_rst,
  input  logic              r_en,
  input  logic [ADDR_W:0]   wptr_async,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W-1:0] r_count,
  output logic [ADDR_W:0]   rptr,
  output logic [ADDR_W:0]   fill_level
`ifdef R_UNDERFLOW_EN
  ,
  output logic              underflow
`endif
);

  logic [ADDR_W:0] wsync1_q;
  logic [ADDR_W:0] wptr_sync_q;
  logic [ADDR_W:0] r_binary_q, r_binary_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] fill_q, fill_d;
  logic [ADDR_W:0] w_bin_sync;
  logic            empty_q, empty_d;
  logic            ae_q, ae_d;
  logic            rd;

  // Plain two-flop chain; nothing else ever looks at wptr_async.
  always_ff @(posedge r_clk or negedge n_rst) begin
    if (!n_rst) begin
      wsync1_q    <= '0;
      wptr_sync_q <= '0;
    end else begin
      wsync1_q    <= wptr_async;
      wptr_sync_q <= wsync1_q;
    end
  end

  always_comb begin
    rd         = r_en & ~empty_q;
    r_binary_d = r_binary_q + {{ADDR_W{1'b0}}, rd};
    rptr_d     = (r_binary_d >> 1) ^ r_binary_d;
    w_bin_sync = '0;
    for (int i = 0; i <= int'(ADDR_W); i++) begin
      w_bin_sync[i] = ^(wptr_sync_q >> i);
    end
    // Modulo subtraction keeps the level correct across pointer wrap.
    fill_d  = w_bin_sync - r_binary_d;
    empty_d = (rptr_d == wptr_sync_q);
    ae_d    = (32'(fill_d) <= AE_THRESH);
  end

  always_ff @(posedge r_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_binary_q <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      empty_q    <= 1'b1;
      ae_q       <= 1'b1;
    end else begin
      r_binary_q <= r_binary_d;
      rptr_q     <= rptr_d;
      fill_q     <= fill_d;
      empty_q    <= empty_d;
      ae_q       <= ae_d;
    end
  end

`ifdef R_UNDERFLOW_EN
  logic underflow_q;

  always_ff @(posedge r_clk or negedge n_rst) begin
    if (!n_rst) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_q | (r_en & empty_q);
    end
  end

  assign underflow = underflow_q;
`endif

  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign r_count      = r_binary_q[ADDR_W-1:0];
  assign rptr         = rptr_q;
  assign fill_level   = fill_q;

endmodule

`default_nettype wire

// File: tb/tb_r_empty.sv
// Self-checking bench for r_empty: per-cycle expectations from an independent binary-domain model.
`default_nettype none
`timescale 1ns/1ps

module tb_r_empty;

  logic       r_clk;
  logic       n_rst;
  logic       r_en;
  logic [7:0] wptr_async;
  logic       empty;
  logic       almost_empty;
  logic [6:0] r_count;
  logic [7:0] rptr;
  logic [7:0] fill_level;
`ifdef R_UNDERFLOW_EN
  logic       underflow;
`endif

  r_empty #(.ADDR_W(7), .AE_THRESH(4)) dut (
    .r_clk        (r_clk),
    .n_rst        (n_rst),
    .r_en         (r_en),
    .wptr_async   (wptr_async),
    .empty        (empty),
    .almost_empty (almost_empty),
    .r_count      (r_count),
    .rptr         (rptr),
    .fill_level   (fill_level)
`ifdef R_UNDERFLOW_EN
    ,
    .underflow    (underflow)
`endif
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  typedef struct packed {
    logic       e;
    logic       ae;
    logic [6:0] rc;
    logic [7:0] rp;
    logic [7:0] fl;
    logic       uf;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  // Model state, kept in binary: write pointer pipeline, read pointer, flags.
  logic [7:0] w_bin;
  logic [7:0] m_s1, m_s2, m_rbin, m_fill;
  logic       m_empty, m_uf;

  function automatic logic [7:0] gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1    = 8'h00;
    m_s2    = 8'h00;
    m_rbin  = 8'h00;
    m_fill  = 8'h00;
    m_empty = 1'b1;
    m_uf    = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle, push the model's prediction, then pop and compare after the edge.
  task automatic step(input logic ren);
    exp_t x;
    logic uf_now;
    r_en       = ren;
    wptr_async = gray(w_bin);
    uf_now     = ren & m_empty;
    if (ren && !m_empty) m_rbin = m_rbin + 8'd1;
    m_fill  = m_s2 - m_rbin;
    m_empty = (m_fill == 8'd0);
    m_uf    = m_uf | uf_now;
    m_s2    = m_s1;
    m_s1    = w_bin;
    x.e  = m_empty;
    x.ae = (m_fill <= 8'd4);
    x.rc = m_rbin[6:0];
    x.rp = gray(m_rbin);
    x.fl = m_fill;
    x.uf = m_uf;
    sb_q.push_back(x);
    @(posedge r_clk);
    #1;
    x = sb_q.pop_front();
    chk("empty", 32'(empty), 32'(x.e));
    chk("almost_empty", 32'(almost_empty), 32'(x.ae));
    chk("r_count", 32'(r_count), 32'(x.rc));
    chk("rptr", 32'(rptr), 32'(x.rp));
    chk("fill_level", 32'(fill_level), 32'(x.fl));
`ifdef R_UNDERFLOW_EN
    chk("underflow", 32'(underflow), 32'(x.uf));
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_rptr"}, 32'(rptr), 32'h00);
    chk({tag, "_rcount"}, 32'(r_count), 32'd0);
    chk({tag, "_fill"}, 32'(fill_level), 32'd0);
`ifdef R_UNDERFLOW_EN
    chk({tag, "_uf"}, 32'(underflow), 32'd0);
`endif
  endtask

  logic [7:0] wrap_rptr [4];

  initial begin
    wrap_rptr[0] = 8'h80;
    wrap_rptr[1] = 8'h00;
    wrap_rptr[2] = 8'h01;
    wrap_rptr[3] = 8'h03;

    r_en       = 1'b0;
    w_bin      = 8'd0;
    wptr_async = 8'h00;
    n_rst      = 1'b1;
    model_reset();

    // Reset asserted between edges must act immediately.
    #12;
    n_rst = 1'b0;
    #1;
    chk_reset_state("rst");
    @(negedge r_clk);
    @(negedge r_clk);
    n_rst = 1'b1;

    // First write: visible exactly after the third edge.
    w_bin = 8'd1;
    step(1'b0);
    step(1'b0);
    chk("first_wr_e2_empty", 32'(empty), 32'd1);
    step(1'b0);
    chk("first_wr_e3_empty", 32'(empty), 32'd0);
    chk("first_wr_e3_fill", 32'(fill_level), 32'd1);
    step(1'b0);

    // Drain four words; extra reads on empty are ignored.
    w_bin = 8'd4;
    repeat (3) step(1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1);
      chk("drain_rcount", 32'(r_count), (i <= 4) ? 32'(i) : 32'd4);
      if (i == 4) chk("drain_empty", 32'(empty), 32'd1);
    end
    chk("drain_rptr", 32'(rptr), 32'h06);

    // Advance the read pointer to 254.
    w_bin = 8'd254;
    repeat (3) step(1'b0);
    for (int i = 0; i < 300 && m_rbin != 8'd254; i++) step(1'b1);
    chk("preload_rptr", 32'(rptr), 32'h81);
    chk("preload_empty", 32'(empty), 32'd1);

    // Wrap through the full pointer space.
    w_bin = 8'd2;
    repeat (3) step(1'b0);
    chk("wrap_fill0", 32'(fill_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk("wrap_rptr", 32'(rptr), 32'(wrap_rptr[i]));
      chk("wrap_fill", 32'(fill_level), 32'(3 - i));
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Almost-empty rises when fill reaches the threshold, not one above it.
    w_bin = 8'd8;
    repeat (3) step(1'b0);
    chk("ae_fill6", 32'(almost_empty), 32'd0);
    step(1'b1);
    chk("ae_fill5", 32'(almost_empty), 32'd0);
    step(1'b1);
    chk("ae_fill4", 32'(almost_empty), 32'd1);
    chk("ae_fill4_level", 32'(fill_level), 32'd4);

    // Drain, then read on empty (underflow when compiled in), then a valid read.
    repeat (4) step(1'b1);
    step(1'b1);
    chk("uf_hold_rcount", 32'(r_count), 32'd8);
`ifdef R_UNDERFLOW_EN
    chk("uf_set", 32'(underflow), 32'd1);
`endif
    w_bin = 8'd9;
    repeat (3) step(1'b0);
    step(1'b1);
`ifdef R_UNDERFLOW_EN
    chk("uf_sticky", 32'(underflow), 32'd1);
`endif

    // Reset in the middle of activity.
    w_bin = 8'd12;
    repeat (3) step(1'b0);
    step(1'b1);
    r_en = 1'b1;
    #3;
    n_rst = 1'b0;
    #1;
    chk_reset_state("midrst");
    model_reset();
    r_en = 1'b0;
    @(negedge r_clk);
    n_rst = 1'b1;
    repeat (4) step(1'b0);
    chk("post_rst_fill", 32'(fill_level), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
